// File: rtl/q2_pkg.sv
// q2_pkg: shared types for the Q2 instruction sequencer.
//   WIDTH_DEF - default datapath/word width
//   opcode_t  - 3-bit opcode held in ir[WIDTH-1:WIDTH-3]
//   state_t   - sequencer FSM states
//   ALU_*     - alu_op encodings
//   ctl_t     - registered strobe vector driven to slices, memory and panel
// Optional feature macro used by the other files: Q2_SINGLE_STEP_EN.
package q2_pkg;

    localparam int WIDTH_DEF = 12;

    typedef enum logic [2:0] {
        OP_LDA = 3'd0,
        OP_STA = 3'd1,
        OP_ADD = 3'd2,
        OP_NOR = 3'd3,
        OP_JMP = 3'd4,
        OP_JZ  = 3'd5,
        OP_SHX = 3'd6,
        OP_HLT = 3'd7
    } opcode_t;

    typedef enum logic [4:0] {
        ST_IDLE, ST_F0, ST_F1, ST_F2,
        ST_O0, ST_O1, ST_O2,
        ST_E0, ST_E1, ST_S0, ST_S1, ST_J0,
        ST_H0, ST_H1, ST_HALT,
        ST_D0, ST_D1, ST_D2
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_NOR  = 2'd2;

    typedef struct packed {
        logic       sw;
        logic       dep;
        logic       wra;
        logic       rda;
        logic       wrp;
        logic       rdp;
        logic       wrx;
        logic       rdx;
        logic       incp_clk;
        logic       xshift;
        logic       xin_zero;
        logic       xin_shift;
        logic       xin_p;
        logic       xin_dbus;
        logic [1:0] alu_op;
        logic       rsts;
        logic       wrs;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
    } ctl_t;

    // Strobe vector seen in IDLE, which is also the reset value.
    function automatic ctl_t idle_ctl();
        ctl_t c;
        c        = '0;
        c.sw     = 1'b1;
        c.halted = 1'b1;
        c.rsts   = 1'b1;
        return c;
    endfunction

    function automatic logic [1:0] alu_sel(opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_NOR:  return ALU_NOR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/q2_if.sv
// q2_if: panel, data-bus and slice/memory strobe bundle of the Q2 sequencer.
//   master - the sequencer: reads run/step/dep_req/ir_in/a_zero, drives strobes and ir
//   slave  - the datapath/panel side
// step exists only when Q2_SINGLE_STEP_EN is defined.
interface q2_if
    import q2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             run;
`ifdef Q2_SINGLE_STEP_EN
    logic             step;
`endif
    logic             dep_req;
    logic [WIDTH-1:0] ir_in;
    logic             a_zero;

    logic             sw, dep;
    logic             wra, rda, wrp, rdp, wrx, rdx, incp_clk;
    logic             xshift;
    logic             xin_zero, xin_shift, xin_p, xin_dbus;
    logic [1:0]       alu_op;
    logic             rsts, wrs;
    logic             mem_rd, mem_wr;
    logic             halted;
    logic [WIDTH-1:0] ir;

    modport master (
`ifdef Q2_SINGLE_STEP_EN
        input  step,
`endif
        input  run, dep_req, ir_in, a_zero,
        output sw, dep, wra, rda, wrp, rdp, wrx, rdx, incp_clk, xshift,
        output xin_zero, xin_shift, xin_p, xin_dbus, alu_op,
        output rsts, wrs, mem_rd, mem_wr, halted, ir
    );

    modport slave (
`ifdef Q2_SINGLE_STEP_EN
        output step,
`endif
        output run, dep_req, ir_in, a_zero,
        input  sw, dep, wra, rda, wrp, rdp, wrx, rdx, incp_clk, xshift,
        input  xin_zero, xin_shift, xin_p, xin_dbus, alu_op,
        input  rsts, wrs, mem_rd, mem_wr, halted, ir
    );
endinterface

// File: rtl/q2_ctl_decode.sv
// q2_ctl_decode: pure combinational map from a sequencer state (plus the
// current opcode, for ALU select and S write) to the strobe vector.
//   state - state being entered on the next clock
//   op    - opcode currently held in the instruction register
//   ctl   - strobe vector to be registered by q2_control
module q2_ctl_decode
    import q2_pkg::*;
(
    input  state_t  state,
    input  opcode_t op,
    output ctl_t    ctl
);
    always_comb begin
        ctl = '0;
        case (state)
            ST_IDLE: ctl = idle_ctl();
            ST_F0, ST_F1: begin
                ctl.rdp    = 1'b1;
                ctl.mem_rd = 1'b1;
            end
            ST_F2, ST_O2, ST_D2: ctl.incp_clk = 1'b1;
            ST_O0, ST_O1: begin
                ctl.rdp      = 1'b1;
                ctl.mem_rd   = 1'b1;
                ctl.xin_dbus = 1'b1;
                ctl.wrx      = (state == ST_O1);
            end
            ST_E0, ST_E1: begin
                ctl.rdx    = 1'b1;
                ctl.mem_rd = 1'b1;
                ctl.alu_op = alu_sel(op);
                ctl.wra    = (state == ST_E1);
                ctl.wrs    = (state == ST_E1) && (op == OP_ADD);
            end
            ST_S0, ST_S1: begin
                ctl.rdx    = 1'b1;
                ctl.rda    = 1'b1;
                ctl.mem_wr = (state == ST_S1);
            end
            ST_J0: ctl.wrp = 1'b1;
            // SHX shifts a zero into X; xshift stays at its default of 0.
            ST_H0, ST_H1: begin
                ctl.xin_shift = 1'b1;
                ctl.wrx       = (state == ST_H1);
            end
            ST_HALT: begin
                ctl.sw     = 1'b1;
                ctl.halted = 1'b1;
            end
            ST_D0, ST_D1: begin
                ctl.dep    = 1'b1;
                ctl.rdp    = 1'b1;
                ctl.mem_wr = (state == ST_D1);
            end
            default: ctl = idle_ctl();
        endcase
    end
endmodule

// File: rtl/q2_control.sv
// q2_control: Q2 instruction sequencer. Holds the instruction register and
// walks fetch/operand/execute; every strobe is a flop loaded from the decode
// of the next state, so outputs are glitch-free and have no input-to-output
// combinational path.
//   clk - sole clock
//   rst - asynchronous, active-low reset
//   bus - q2_if.master: panel inputs, data bus, a_zero, all strobes, ir
// Q2_SINGLE_STEP_EN adds the step input and single-instruction stepping.
//
// state | meaning
// IDLE  | panel owns bus, waiting for run / step / deposit
// F0-F2 | fetch instruction word, load ir, increment P
// O0-O2 | fetch operand address into X, increment P
// E0-E1 | memory[X] through ALU into A (LDA/ADD/NOR)
// S0-S1 | A to memory[X] (STA)
// J0    | X to P (JMP, JZ taken)
// H0-H1 | shift X (SHX)
// HALT  | stopped by HLT until run drops
// D0-D2 | panel deposit at P, increment P
module q2_control
    import q2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    q2_if.master bus
);
    state_t           state_q, state_nx, end_state;
    ctl_t             ctl_q, ctl_nx;
    logic [WIDTH-1:0] ir_q;
    opcode_t          op;
    logic             dep_q, dep_rise, step_rise;
    logic             step_mode_q, step_mode_nx;

`ifdef Q2_SINGLE_STEP_EN
    logic step_q;
    assign step_rise = bus.step & ~step_q;
`else
    assign step_rise = 1'b0;
`endif

    assign op       = opcode_t'(ir_q[WIDTH-1 -: 3]);
    assign dep_rise = bus.dep_req & ~dep_q;
    // A stepped instruction always returns to IDLE when it ends.
    assign end_state = (bus.run && !step_mode_q) ? ST_F0 : ST_IDLE;

    always_comb begin
        state_nx     = state_q;
        step_mode_nx = step_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_nx     = ST_F0;
                    step_mode_nx = 1'b0;
                end else if (step_rise) begin
                    state_nx     = ST_F0;
                    step_mode_nx = 1'b1;
                end else if (dep_rise) begin
                    state_nx = ST_D0;
                end
            end
            ST_F0: state_nx = ST_F1;
            ST_F1: state_nx = ST_F2;
            ST_F2: begin
                if (op == OP_HLT)      state_nx = ST_HALT;
                else if (op == OP_SHX) state_nx = ST_H0;
                else                   state_nx = ST_O0;
            end
            ST_O0: state_nx = ST_O1;
            ST_O1: state_nx = ST_O2;
            ST_O2: begin
                case (op)
                    OP_JMP:  state_nx = ST_J0;
                    OP_JZ:   state_nx = bus.a_zero ? ST_J0 : end_state;
                    OP_STA:  state_nx = ST_S0;
                    default: state_nx = ST_E0;
                endcase
            end
            ST_E0:   state_nx = ST_E1;
            ST_S0:   state_nx = ST_S1;
            ST_H0:   state_nx = ST_H1;
            ST_E1, ST_S1, ST_J0, ST_H1: state_nx = end_state;
            ST_HALT: if (!bus.run) state_nx = ST_IDLE;
            ST_D0:   state_nx = ST_D1;
            ST_D1:   state_nx = ST_D2;
            ST_D2:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (state_nx == ST_IDLE) step_mode_nx = 1'b0;
    end

    q2_ctl_decode u_decode (
        .state (state_nx),
        .op    (op),
        .ctl   (ctl_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ctl_q       <= idle_ctl();
            ir_q        <= '0;
            dep_q       <= 1'b0;
            step_mode_q <= 1'b0;
`ifdef Q2_SINGLE_STEP_EN
            step_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_nx;
            ctl_q       <= ctl_nx;
            dep_q       <= bus.dep_req;
            step_mode_q <= step_mode_nx;
`ifdef Q2_SINGLE_STEP_EN
            step_q      <= bus.step;
`endif
            if (state_q == ST_F1) ir_q <= bus.ir_in;
        end
    end

    assign bus.sw        = ctl_q.sw;
    assign bus.dep       = ctl_q.dep;
    assign bus.wra       = ctl_q.wra;
    assign bus.rda       = ctl_q.rda;
    assign bus.wrp       = ctl_q.wrp;
    assign bus.rdp       = ctl_q.rdp;
    assign bus.wrx       = ctl_q.wrx;
    assign bus.rdx       = ctl_q.rdx;
    assign bus.incp_clk  = ctl_q.incp_clk;
    assign bus.xshift    = ctl_q.xshift;
    assign bus.xin_zero  = ctl_q.xin_zero;
    assign bus.xin_shift = ctl_q.xin_shift;
    assign bus.xin_p     = ctl_q.xin_p;
    assign bus.xin_dbus  = ctl_q.xin_dbus;
    assign bus.alu_op    = ctl_q.alu_op;
    assign bus.rsts      = ctl_q.rsts;
    assign bus.wrs       = ctl_q.wrs;
    assign bus.mem_rd    = ctl_q.mem_rd;
    assign bus.mem_wr    = ctl_q.mem_wr;
    assign bus.halted    = ctl_q.halted;
    assign bus.ir        = ir_q;
endmodule

// File: tb/tb_q2_control.sv
// tb_q2_control: self-checking bench for q2_control. A behavioural model turns
// each started instruction into the list of per-cycle strobe sets it must
// produce and compares every cycle; directed runs pin cycle counts by hand.
module tb_q2_control;
    localparam int B_HALTED = 0, B_MEM_WR = 1, B_MEM_RD = 2, B_WRS = 3, B_RSTS = 4;
    localparam int B_XIN_DBUS = 7, B_XIN_SHIFT = 9, B_INCP = 12, B_RDX = 13, B_WRX = 14;
    localparam int B_RDP = 15, B_WRP = 16, B_RDA = 17, B_WRA = 18, B_DEP = 19, B_SW = 20;

    localparam logic [20:0] ONE = 21'd1;
    localparam logic [20:0] V_IDLE = (ONE << B_SW) | (ONE << B_HALTED) | (ONE << B_RSTS);
    localparam logic [20:0] V_HALT = (ONE << B_SW) | (ONE << B_HALTED);
    localparam logic [20:0] V_FET  = (ONE << B_RDP) | (ONE << B_MEM_RD);
    localparam logic [20:0] V_INCP = ONE << B_INCP;
    localparam logic [20:0] V_O0   = V_FET | (ONE << B_XIN_DBUS);
    localparam logic [20:0] V_O1   = V_O0 | (ONE << B_WRX);
    localparam logic [20:0] V_S0   = (ONE << B_RDX) | (ONE << B_RDA);
    localparam logic [20:0] V_S1   = V_S0 | (ONE << B_MEM_WR);
    localparam logic [20:0] V_J0   = ONE << B_WRP;
    localparam logic [20:0] V_H0   = ONE << B_XIN_SHIFT;
    localparam logic [20:0] V_H1   = V_H0 | (ONE << B_WRX);
    localparam logic [20:0] V_D0   = (ONE << B_DEP) | (ONE << B_RDP);
    localparam logic [20:0] V_D1   = V_D0 | (ONE << B_MEM_WR);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    q2_if #(.WIDTH(12)) bus ();
    q2_control #(.WIDTH(12)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [20:0] dut_vec;
    assign dut_vec = {bus.sw, bus.dep, bus.wra, bus.rda, bus.wrp, bus.rdp, bus.wrx,
                      bus.rdx, bus.incp_clk, bus.xshift, bus.xin_zero, bus.xin_shift,
                      bus.xin_p, bus.xin_dbus, bus.alu_op, bus.rsts, bus.wrs,
                      bus.mem_rd, bus.mem_wr, bus.halted};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [20:0] plan[$];
    int          rest = 0;   // 0 idle, 1 halted, 2 instruction just ended
    bit          stepmode = 0;
    bit          dep_prev = 0;
    bit          step_prev = 0;

    task automatic start_instr(input bit sm);
        logic [2:0]  opc;
        logic [1:0]  alu;
        logic [20:0] e0;
        opc = bus.ir_in[11:9];
        stepmode = sm;
        rest = 2;
        plan.delete();
        plan.push_back(V_FET);
        plan.push_back(V_FET);
        plan.push_back(V_INCP);
        if (opc == 3'd7) begin
            plan.push_back(V_HALT);
            rest = 1;
        end else if (opc == 3'd6) begin
            plan.push_back(V_H0);
            plan.push_back(V_H1);
        end else begin
            plan.push_back(V_O0);
            plan.push_back(V_O1);
            plan.push_back(V_INCP);
            if (opc == 3'd4 || (opc == 3'd5 && bus.a_zero)) begin
                plan.push_back(V_J0);
            end else if (opc == 3'd1) begin
                plan.push_back(V_S0);
                plan.push_back(V_S1);
            end else if (opc != 3'd5) begin
                alu = (opc == 3'd2) ? 2'd1 : (opc == 3'd3) ? 2'd2 : 2'd0;
                e0 = (ONE << B_RDX) | (ONE << B_MEM_RD) | (21'(alu) << 5);
                plan.push_back(e0);
                plan.push_back(e0 | (ONE << B_WRA) | ((opc == 3'd2) ? (ONE << B_WRS) : 21'd0));
            end
        end
    endtask

    always @(posedge clk) begin
        logic [20:0] want;
        bit          dep_rise, step_rise;
        if (!rst) begin
            plan.delete();
            rest = 0;
            stepmode = 0;
            dep_prev = 0;
            step_prev = 0;
        end else begin
            dep_rise = bus.dep_req && !dep_prev;
`ifdef Q2_SINGLE_STEP_EN
            step_rise = bus.step && !step_prev;
            step_prev = bus.step;
`else
            step_rise = 0;
`endif
            dep_prev = bus.dep_req;
            if (plan.size() == 0) begin
                if (rest == 0) begin
                    if (bus.run) start_instr(0);
                    else if (step_rise) start_instr(1);
                    else if (dep_rise) plan = '{V_D0, V_D1, V_INCP, V_IDLE};
                end else if (rest == 1) begin
                    if (!bus.run) begin rest = 0; stepmode = 0; end
                end else begin
                    if (bus.run && !stepmode) start_instr(0);
                    else begin rest = 0; stepmode = 0; end
                end
            end
            if (plan.size() != 0) want = plan.pop_front();
            else want = (rest == 1) ? V_HALT : V_IDLE;
            #1;
            chk($sformatf("cycle@%0t", $time), 32'(dut_vec), 32'(want));
        end
    end

    // ---------------- directed runs ----------------
    logic [20:0] tr[1:24];
    int          len;

    function automatic logic [31:0] col(input int b);
        logic [31:0] r;
        r = '0;
        for (int k = 1; k <= 24; k++) r[k] = tr[k][b];
        return r;
    endfunction

    // mode 0 run pulse, 1 deposit edge, 2 step pulse, 3 step held
    task automatic run_one(input int mode, input logic [11:0] instr, input logic az,
                           input logic dep_too);
        bit done;
        @(negedge clk);
        bus.ir_in  = instr;
        bus.a_zero = az;
        if (mode == 0) begin
            bus.run = 1'b1;
            bus.dep_req = dep_too;
        end else if (mode == 1) begin
            bus.dep_req = 1'b1;
        end
`ifdef Q2_SINGLE_STEP_EN
        if (mode >= 2) bus.step = 1'b1;
`endif
        len = -1;
        done = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            tr[k] = dut_vec;
            if (!done && dut_vec[B_HALTED]) begin
                len = k - 1;
                done = 1;
            end
            @(negedge clk);
            if (k == 1) begin
                bus.run = 1'b0;
`ifdef Q2_SINGLE_STEP_EN
                if (mode == 2) bus.step = 1'b0;
`endif
            end
        end
        bus.dep_req = 1'b0;
`ifdef Q2_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        bus.run = 0;
        bus.dep_req = 0;
        bus.ir_in = '0;
        bus.a_zero = 0;
`ifdef Q2_SINGLE_STEP_EN
        bus.step = 0;
`endif
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(dut_vec), 32'h0010_0011);
        chk("reset_ir", 32'(bus.ir), 32'h0);
        rst = 1'b1;

        run_one(0, 12'o7000, 0, 0);
        chk("hlt_len", len, 3);
        chk("hlt_rdp", col(B_RDP), 32'h6);
        chk("hlt_incp", col(B_INCP), 32'h8);

        run_one(0, 12'o0000, 0, 0);
        chk("lda_len", len, 8);
        chk("lda_wrx", col(B_WRX), 32'h20);
        chk("lda_dbus", col(B_XIN_DBUS), 32'h30);
        chk("lda_wra", col(B_WRA), 32'h100);
        chk("lda_rdx", col(B_RDX), 32'h180);
        chk("lda_alu", 32'(tr[8][6:5]), 32'd0);
        chk("lda_wrs", col(B_WRS), 32'h0);

        run_one(0, 12'o2000, 0, 0);
        chk("add_wrs", col(B_WRS), 32'h100);
        chk("add_alu", 32'(tr[8][6:5]), 32'd1);
        chk("add_ir", 32'(bus.ir), 32'o2000);

        run_one(0, 12'o3000, 0, 0);
        chk("nor_alu", 32'(tr[8][6:5]), 32'd2);

        run_one(0, 12'o1000, 0, 0);
        chk("sta_len", len, 8);
        chk("sta_memwr", col(B_MEM_WR), 32'h100);
        chk("sta_rda", col(B_RDA), 32'h180);

        run_one(0, 12'o4000, 0, 0);
        chk("jmp_len", len, 7);
        chk("jmp_wrp", col(B_WRP), 32'h80);

        run_one(0, 12'o5000, 0, 0);
        chk("jz0_len", len, 6);
        chk("jz0_wrp", col(B_WRP), 32'h0);

        run_one(0, 12'o5000, 1, 0);
        chk("jz1_len", len, 7);
        chk("jz1_wrp", col(B_WRP), 32'h80);

        run_one(0, 12'o6000, 0, 0);
        chk("shx_len", len, 5);
        chk("shx_wrx", col(B_WRX), 32'h20);
        chk("shx_xsel", col(B_XIN_SHIFT), 32'h30);

        run_one(1, 12'o0000, 0, 0);
        chk("dep_len", len, 3);
        chk("dep_dep", col(B_DEP), 32'h6);
        chk("dep_memwr", col(B_MEM_WR), 32'h4);
        chk("dep_incp", col(B_INCP), 32'h8);

        run_one(0, 12'o6000, 0, 1);
        chk("runwin_len", len, 5);
        chk("runwin_dep", col(B_DEP), 32'h0);

`ifdef Q2_SINGLE_STEP_EN
        run_one(2, 12'o1000, 0, 0);
        chk("step_len", len, 8);
        chk("step_memwr", col(B_MEM_WR), 32'h100);
        run_one(3, 12'o1000, 0, 0);
        chk("stephold_memwr", col(B_MEM_WR), 32'h100);
`endif

        // reset in the middle of E1 while wra is high
        @(negedge clk);
        bus.ir_in = 12'o0123;
        bus.run = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.wra) found = 1;
        end
        chk("e1_reached", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_wra", 32'(bus.wra), 32'd0);
        chk("rst_vec", 32'(dut_vec), 32'h0010_0011);
        chk("rst_ir", 32'(bus.ir), 32'h0);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // randomized phase; ir_in/a_zero only move while the model is resting
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (plan.size() == 0 && rest != 2) begin
                bus.ir_in = 12'($urandom_range(0, 4095));
                bus.a_zero = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 5) == 0) bus.dep_req = ~bus.dep_req;
`ifdef Q2_SINGLE_STEP_EN
            if ($urandom_range(0, 4) == 0) bus.step = ~bus.step;
`endif
        end
        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
